// File: rtl/lit_bank_buffer.sv
// lit_bank_buffer: one history bank for the literal/copy path.
//   - 2**ADDR_WIDTH x DATA_WIDTH byte-writable data RAM (contents survive reset)
//   - per-byte "written" flag array, cleared by reset or by the clear sequencer
//   - fixed one-cycle copy-read port returning data plus written mask
// Build option: define LIT_BANK_FWD_EN for write-first forwarding on a
// same-cycle write/read to one address; default build is read-first.
module lit_bank_buffer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_valid,
  input  logic                    wr_valid,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   rd_data_out,
  output logic [DATA_WIDTH/8-1:0] rd_byte_valid_out,
  output logic                    rd_valid_out,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    wr_drop_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  // Counter is one bit wider than the address so the terminal test never wraps.
  localparam logic [ADDR_WIDTH:0] COUNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NB-1:0]         rd_bv_q, rd_bv_d;
  logic                  drop_err_q, drop_err_d;

  logic [DATA_WIDTH-1:0] ram   [DEPTH];
  logic [NB-1:0]         flags [DEPTH];

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NB-1:0]         rd_flags;

  // Writes are accepted only while idle; during a clear they are dropped.
  assign wr_en = wr_valid && (state_q == IDLE);

  // Data RAM: byte-lane write, no reset.
  // NOTE: the data array is deliberately not reset so it maps onto a RAM macro;
  // the written flags alone decide whether a byte is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_byte_valid[i]) ram[wr_address][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Written-flag array: set by writes, zeroed by reset and one word per clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) flags[a] <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_byte_valid[i]) flags[wr_address][i] <= 1'b1;
        end
      end
      if (state_q == CLEAR) flags[count_q[ADDR_WIDTH-1:0]] <= '0;
    end
  end

  // Read-port word and flags, optionally merged with a same-address write.
  always_comb begin
    rd_word  = ram[rd_address];
    rd_flags = flags[rd_address];
`ifdef LIT_BANK_FWD_EN
    if (wr_en && (wr_address == rd_address)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_byte_valid[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
      rd_flags = rd_flags | wr_byte_valid;
    end
`endif
  end

  // Next-state logic: clear sequencer, read response, sticky drop error.
  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_bv_d    = rd_bv_q;
    drop_err_d = drop_err_q;

    if (rd_req) begin
      rd_data_d = rd_word;
      rd_bv_d   = (state_q == CLEAR) ? '0 : rd_flags;
    end

    case (state_q)
      IDLE: begin
        if (clear_start) state_d = CLEAR;
      end
      CLEAR: begin
        if (wr_valid) drop_err_d = 1'b1;
        if (count_q == COUNT_LAST) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q + COUNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_bv_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_bv_q    <= rd_bv_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign rd_valid_out      = rd_valid_q;
  assign rd_data_out       = rd_data_q;
  assign rd_byte_valid_out = rd_bv_q;
  assign clear_busy        = (state_q == CLEAR);
  assign wr_drop_err       = drop_err_q;

endmodule

// File: tb/tb_lit_bank_buffer.sv
// Directed bench for lit_bank_buffer: reset, byte-lane writes, same-cycle
// write/read, full clear, writes/restarts during clear, reset mid-clear.
module tb_lit_bank_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] wr_data;
  logic [8:0]  wr_address;
  logic [7:0]  wr_byte_valid;
  logic        wr_valid;
  logic        rd_req;
  logic [8:0]  rd_address;
  logic [63:0] rd_data_out;
  logic [7:0]  rd_byte_valid_out;
  logic        rd_valid_out;
  logic        clear_start;
  logic        clear_busy;
  logic        wr_drop_err;

  int n_pass  = 0;
  int n_total = 0;

  lit_bank_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_address(wr_address),
    .wr_byte_valid(wr_byte_valid), .wr_valid(wr_valid),
    .rd_req(rd_req), .rd_address(rd_address),
    .rd_data_out(rd_data_out), .rd_byte_valid_out(rd_byte_valid_out),
    .rd_valid_out(rd_valid_out),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .wr_drop_err(wr_drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_valid = 1'b1; wr_address = a; wr_data = d; wr_byte_valid = be;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a);
    rd_req = 1'b1; rd_address = a;
    tick();
    rd_req = 1'b0;
  endtask

  function automatic logic [63:0] fill_word(input int a);
    return 64'h0123_4567_0000_0000 | 64'(a);
  endfunction

  int busy;

  initial begin
    rst_n = 1'b0; wr_data = '0; wr_address = '0; wr_byte_valid = '0; wr_valid = 1'b0;
    rd_req = 1'b0; rd_address = '0; clear_start = 1'b0;

    // 1. Reset state, then first read.
    repeat (3) tick();
    check("rst_rd_valid", 64'(rd_valid_out), 64'd0);
    check("rst_rd_data",  rd_data_out, 64'd0);
    check("rst_rd_bv",    64'(rd_byte_valid_out), 64'd0);
    check("rst_busy",     64'(clear_busy), 64'd0);
    check("rst_drop_err", 64'(wr_drop_err), 64'd0);
    rst_n = 1'b1;
    tick();
    do_read(9'h000);
    check("t1_rd_valid", 64'(rd_valid_out), 64'd1);
    check("t1_rd_bv",    64'(rd_byte_valid_out), 64'h00);
    tick();
    check("t1_valid_drop", 64'(rd_valid_out), 64'd0);

    // 2. Partial writes merge by lane.
    do_write(9'h05A, 64'h1122334455667788, 8'h0F);
    do_read(9'h05A);
    check("t2_lo32", 64'(rd_data_out[31:0]), 64'h55667788);
    check("t2_bv0F", 64'(rd_byte_valid_out), 64'h0F);
    do_write(9'h05A, 64'hAAAAAAAAAAAAAAAA, 8'hF0);
    do_read(9'h05A);
    check("t2_merged", rd_data_out, 64'hAAAAAAAA55667788);
    check("t2_bvFF",   64'(rd_byte_valid_out), 64'hFF);
    tick();
    check("t2_hold_data", rd_data_out, 64'hAAAAAAAA55667788);

    // 3. Same-cycle write and read of a fresh address.
    wr_valid = 1'b1; wr_address = 9'h1FF; wr_data = 64'hDEADBEEF00000000; wr_byte_valid = 8'hFF;
    rd_req = 1'b1; rd_address = 9'h1FF;
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
`ifdef LIT_BANK_FWD_EN
    check("t3_fwd_bv",   64'(rd_byte_valid_out), 64'hFF);
    check("t3_fwd_data", rd_data_out, 64'hDEADBEEF00000000);
`else
    check("t3_rf_bv", 64'(rd_byte_valid_out), 64'h00);
`endif
    do_read(9'h1FF);
    check("t3_next_bv",   64'(rd_byte_valid_out), 64'hFF);
    check("t3_next_data", rd_data_out, 64'hDEADBEEF00000000);

    // 4. Fill the bank, clear it, check flags gone and data intact.
    for (int a = 0; a < 512; a++) do_write(9'(a), fill_word(a), 8'hFF);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    busy = 0;
    while (clear_busy && busy < 1000) begin
      busy++;
      if (busy == 5) begin rd_req = 1'b1; rd_address = 9'h1FF; end
      if (busy == 6) begin
        rd_req = 1'b0;
        check("t4_rd_in_clear_valid", 64'(rd_valid_out), 64'd1);
        check("t4_rd_in_clear_bv",    64'(rd_byte_valid_out), 64'h00);
      end
      tick();
    end
    check("t4_busy_cycles", 64'(busy), 64'd512);
    for (int a = 0; a < 512; a++) begin
      rd_req = 1'b1; rd_address = 9'(a);
      tick();
      check("t4_post_bv",   64'(rd_byte_valid_out), 64'h00);
      check("t4_post_data", rd_data_out, fill_word(a));
    end
    rd_req = 1'b0;

    // 5. Write and restart attempt during clear.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    busy = 0;
    while (clear_busy && busy < 1000) begin
      busy++;
      if (busy == 10) begin
        wr_valid = 1'b1; wr_address = 9'h003; wr_data = '1; wr_byte_valid = 8'hFF;
      end
      if (busy == 11) begin
        wr_valid = 1'b0;
        check("t5_drop_err_set", 64'(wr_drop_err), 64'd1);
      end
      if (busy == 20) clear_start = 1'b1;
      if (busy == 21) clear_start = 1'b0;
      tick();
    end
    check("t5_busy_cycles", 64'(busy), 64'd512);
    check("t5_drop_err_sticky", 64'(wr_drop_err), 64'd1);
    repeat (3) tick();
    check("t5_no_restart", 64'(clear_busy), 64'd0);
    do_read(9'h003);
    check("t5_dropped_bv",   64'(rd_byte_valid_out), 64'h00);
    check("t5_dropped_data", rd_data_out, fill_word(3));

    // 6. Reset in the middle of a clear.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (99) tick();
    check("t6_busy_before_rst", 64'(clear_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy_async", 64'(clear_busy), 64'd0);
    check("t6_drop_err_rst", 64'(wr_drop_err), 64'd0);
    check("t6_rd_valid_rst", 64'(rd_valid_out), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle_after", 64'(clear_busy), 64'd0);
    do_write(9'h010, 64'hFFFFFFFFFFFFFFFF, 8'h3C);
    do_read(9'h010);
    check("t6_wr_bv",   64'(rd_byte_valid_out), 64'h3C);
    check("t6_wr_data", rd_data_out, 64'h0123FFFFFFFF0010);
    check("t6_drop_err_clear", 64'(wr_drop_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lit_bank_buffer.md
Name: lit_bank_buffer

Overview:
- Downstream consumer of the literal/copy selector stage.
- One instance per history bank: a 512 x 64-bit byte-writable history RAM plus a per-byte "written" flag array.
- Accepts the selector's merged write stream (literal or copy write-back) and serves copy-read requests with data plus a per-byte written mask, so the copy engine can detect not-yet-available bytes and retry.
- A clear sequencer recycles the bank between pages.

Parameters:
- ADDR_WIDTH, 9, word address width; bank depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, data word width; byte lanes = DATA_WIDTH/8.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_data  input  64  write data from selector data_out.
- wr_address  input  9  write word address from selector address_out.
- wr_byte_valid  input  8  byte enables from selector byte_valid_out.
- wr_valid  input  1  write strobe from selector valid_out.
- rd_req  input  1  copy-read request.
- rd_address  input  9  copy-read word address.
- rd_data_out  output  64  read data.
- rd_byte_valid_out  output  8  per-byte written flags of the read word.
- rd_valid_out  output  1  read response strobe.
- clear_start  input  1  pulse: start clearing all written flags.
- clear_busy  output  1  clear sequence in progress.
- wr_drop_err  output  1  sticky: a write arrived while clearing.

Behaviour:
Reset (rst_n low, asynchronous):
- All written flags go to 0.
- rd_valid_out, rd_data_out, rd_byte_valid_out, clear_busy, wr_drop_err go to 0.
- FSM goes to IDLE and the clear counter goes to 0.
- Data RAM contents are not reset.
- Reset asserted mid-clear aborts the clear; all flags are 0 anyway.

Write (IDLE only):
- On wr_valid, for each lane i with wr_byte_valid[i]=1, RAM byte i at wr_address takes wr_data[8i+7:8i] and flag[wr_address][i] is set to 1.
- Lanes with enable 0 are untouched.
- wr_byte_valid=0 with wr_valid=1 is a legal no-op.

Read, fixed 1-cycle latency:
- rd_req sampled at edge T drives rd_valid_out=1 after edge T, with the data and flags of rd_address.
- When rd_req is low, rd_valid_out=0 and rd_data_out/rd_byte_valid_out hold their last values.
- Back-to-back reads are accepted every cycle.
- No backpressure on either port.

Same-cycle write and read to the same address: see Optional Feature. Different addresses are fully independent.

FSM:
- IDLE -> CLEAR on clear_start.
- In CLEAR:
  - Each cycle, flags[count] go to 0 and count increments.
  - At count = 2**ADDR_WIDTH-1, the flags are cleared, count returns to 0 and the FSM goes to IDLE.
  - The clear takes exactly 512 cycles; clear_busy is high for exactly those cycles.
- clear_start while in CLEAR is ignored (no restart).
- wr_valid during CLEAR: the write is dropped and wr_drop_err is set. wr_drop_err clears only on reset.
- rd_req during CLEAR is served, but rd_byte_valid_out is forced to 0; rd_data_out is don't-care.
- clear_start and wr_valid in the same IDLE cycle: the write commits, then clearing starts; that word is cleared in its turn.

Width rules: the counter is ADDR_WIDTH+1 bits internally, so the terminal test does not wrap.

Optional Feature:
Macro: LIT_BANK_FWD_EN
- Defined: write-first forwarding. A read sampled at the same edge as a write to the same address returns the merged result: new bytes for enabled lanes, old bytes otherwise, with flags OR-ed with wr_byte_valid.
- Undefined: read-first. The same case returns the pre-write data and flags. The write still commits and is visible to reads from the next cycle.

Test Plan:
1. Reset, then read address 0x000 -> rd_valid_out=1 one cycle later, rd_byte_valid_out=0x00; all outputs 0 during reset.
2. Write 0x1122334455667788 to 0x05A with byte_valid 0x0F, next cycle read 0x05A -> low 32 bits 0x55667788, rd_byte_valid_out=0x0F. Then write 0xAA.. with 0xF0 and read again -> 0xAAAAAAAA55667788, flags 0xFF.
3. Same-cycle write (0x1FF, 0xFF, data 0xDEADBEEF00000000) and read of 0x1FF from a fresh bank:
   - LIT_BANK_FWD_EN defined -> flags 0xFF and the new data.
   - Undefined -> flags 0x00; a read one cycle later returns 0xFF.
4. Fill 0x000..0x1FF with flags 0xFF, pulse clear_start -> clear_busy high for exactly 512 cycles. A read of 0x1FF during clear returns 0x00. After clear, every address reads flags 0x00 and the data is unchanged.
5. Write during CLEAR at cycle 10, and a second clear_start at cycle 20 -> wr_drop_err=1 and stays 1; the clear still ends at cycle 512; no restart.
6. Assert rst_n low at clear cycle 100 -> clear_busy=0 immediately (asynchronously), FSM IDLE. After release, writes are accepted and wr_drop_err=0.
